// File: rtl/ao_sel_pkg.sv
// rtl/ao_sel_pkg.sv - shared types and constants for the AND-OR select pipe
package ao_sel_pkg;

  typedef enum logic {
    AO_MODE_OR   = 1'b0,
    AO_MODE_PRIO = 1'b1
  } ao_mode_e;

  localparam int AO_WIDTH_MIN = 1;
  localparam int AO_WIDTH_MAX = 64;
  localparam int AO_NCH_MIN   = 2;
  localparam int AO_NCH_MAX   = 16;
  localparam int AO_BUF_DEPTH = 2;

endpackage

// File: rtl/ao_sel_fifo2.sv
// rtl/ao_sel_fifo2.sv - 2-entry in-order result buffer with registered input ready
module ao_sel_fifo2
  import ao_sel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  assign push = in_valid_i && in_ready_q;
  assign pop  = (cnt_q != 2'd0) && out_ready_i;

  // The head always lives in slot0, so popping shifts slot1 forward.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        slot0_d = in_data_i;
      end else begin
        slot1_d = in_data_i;
      end
      cnt_d = cnt_d + 2'd1;
    end
    in_ready_d = (cnt_d < 2'(AO_BUF_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? slot0_q : '0;

endmodule

// File: rtl/ao_sel_pipe.sv
// rtl/ao_sel_pipe.sv - AND-OR / priority channel select feeding a 2-entry result buffer
module ao_sel_pipe
  import ao_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 3
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [NCH-1:0]       SEL,
  input  logic [NCH*WIDTH-1:0] DATA,
  input  logic                 MODE,
  output logic                 Q_VALID,
  input  logic                 Q_READY,
  output logic [WIDTH-1:0]     Q,
  input  logic                 ERR_CLR,
  output logic                 SEL_ERR
);

  ao_mode_e         mode;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             multi_sel;
  logic             accept;
  logic             err_set;
  logic             sel_err_q, sel_err_d;

  assign mode = ao_mode_e'(MODE);

  always_comb begin
    result = '0;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL[i]) begin
        if (mode == AO_MODE_OR) begin
          result = result | DATA[i*WIDTH +: WIDTH];
        end else if (!found) begin
          result = DATA[i*WIDTH +: WIDTH];
          found  = 1'b1;
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_sel = |(SEL & (SEL - NCH'(1)));
  assign accept    = IN_VALID && IN_READY;
  assign err_set   = accept && (mode == AO_MODE_OR) && multi_sel;

  always_comb begin
    sel_err_d = sel_err_q;
    if (err_set) begin
      sel_err_d = 1'b1;
    end else if (ERR_CLR) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign SEL_ERR = sel_err_q;

  ao_sel_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RSTB),
    .in_valid_i (IN_VALID),
    .in_data_i  (result),
    .in_ready_o (IN_READY),
    .out_valid_o(Q_VALID),
    .out_ready_i(Q_READY),
    .out_data_o (Q)
  );

endmodule

// File: tb/tb_ao_sel_pipe.sv
// tb/tb_ao_sel_pipe.sv - self-checking bench for ao_sel_pipe
module tb_ao_sel_pipe;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rstb;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   sel;
  logic [N*W-1:0] data;
  logic           mode;
  logic           q_valid;
  logic           q_ready;
  logic [W-1:0]   q;
  logic           err_clr;
  logic           sel_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ao_sel_pipe #(.WIDTH(W), .NCH(N)) dut (
    .CLK     (clk),
    .RSTB    (rstb),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .SEL     (sel),
    .DATA    (data),
    .MODE    (mode),
    .Q_VALID (q_valid),
    .Q_READY (q_ready),
    .Q       (q),
    .ERR_CLR (err_clr),
    .SEL_ERR (sel_err)
  );

  typedef struct {
    logic [N-1:0]   sel;
    logic [N*W-1:0] data;
    logic           mode;
    logic [W-1:0]   exp_q;
    logic           exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per output bit, OR over enabled channels; priority picks first enabled channel.
  function automatic logic [W-1:0] ref_result(input logic [N-1:0] s, input logic [N*W-1:0] d,
                                              input logic m);
    logic [W-1:0] r;
    int k;
    r = '0;
    if (s == '0) return r;
    if (m) begin
      k = 0;
      while (!s[k]) k++;
      return d[k*W +: W];
    end
    for (int b = 0; b < W; b++) begin
      for (int c = 0; c < N; c++) begin
        if (s[c] && d[c*W + b]) r[b] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic multi_bits(input logic [N-1:0] s);
    return $countones(s) > 1;
  endfunction

  task automatic do_reset();
    rstb = 1'b0;
    #7;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sel_err", sel_err, 0);
    @(negedge clk);
    rstb = 1'b1;
    step();
    chk("rst_in_ready_first_edge", in_ready, 1);
  endtask

  logic [W-1:0] model_q[$];
  logic         model_err;
  logic         push, pop;

  initial begin
    rstb = 1'b0; in_valid = 0; sel = '0; data = '0; mode = 0; q_ready = 1; err_clr = 0;

    vecs[0] = '{3'b101, 24'h30FF0F, 1'b0, 8'h3F, 1'b1};
    vecs[1] = '{3'b101, 24'h30FF0F, 1'b1, 8'h0F, 1'b0};
    vecs[2] = '{3'b000, 24'h30FF0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{3'b000, 24'h30FF0F, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{3'b010, 24'h30FF0F, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{3'b110, 24'h30FF0F, 1'b1, 8'hFF, 1'b0};
    vecs[6] = '{3'b100, 24'h30FF0F, 1'b1, 8'h30, 1'b0};
    vecs[7] = '{3'b111, 24'hA55A81, 1'b0, 8'hFF, 1'b1};
    vecs[8] = '{3'b011, 24'hA55A81, 1'b0, 8'hDB, 1'b1};
    vecs[9] = '{3'b111, 24'hA55A81, 1'b1, 8'h81, 1'b0};

    do_reset();

    // Table vectors: clear error, send one beat, check result one cycle later.
    for (int v = 0; v < 10; v++) begin
      in_valid = 0; err_clr = 1; q_ready = 1;
      step();
      err_clr = 0;
      in_valid = 1; sel = vecs[v].sel; data = vecs[v].data; mode = vecs[v].mode;
      step();
      in_valid = 0; sel = '1; data = '1; mode = ~mode;
      chk($sformatf("vec%0d_q_valid", v), q_valid, 1);
      chk($sformatf("vec%0d_q", v), q, vecs[v].exp_q);
      chk($sformatf("vec%0d_sel_err", v), sel_err, vecs[v].exp_err);
      step();
      chk($sformatf("vec%0d_drained", v), q_valid, 0);
    end

    // Backpressure: three beats offered, two held, released in order.
    q_ready = 0; mode = 1; sel = 3'b001;
    in_valid = 1; data = 24'h000011; step();
    data = 24'h000022; step();
    chk("bp_in_ready_full", in_ready, 0);
    data = 24'h000033; step();
    chk("bp_in_ready_still_full", in_ready, 0);
    chk("bp_head_held", q, 8'h11);
    in_valid = 0; step();
    chk("bp_head_stable", q, 8'h11);
    q_ready = 1; step();
    chk("bp_second_out", q, 8'h22);
    chk("bp_in_ready_after_pop", in_ready, 1);
    step();
    chk("bp_empty_valid", q_valid, 0);
    chk("bp_empty_q", q, 0);

    // Streaming: ten back-to-back beats.
    q_ready = 1; mode = 1; sel = 3'b001;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; data = 24'(i + 8'h40);
      step();
      chk($sformatf("stream%0d_q", i), {q_valid, q}, {1'b1, 8'(i + 8'h40)});
      chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 0; step();
    chk("stream_end_valid", q_valid, 0);

    // Simultaneous set and clear of SEL_ERR.
    err_clr = 1; step();
    in_valid = 1; mode = 0; sel = 3'b011; err_clr = 1; step();
    chk("errclr_same_cycle", sel_err, 1);
    in_valid = 0; step();
    chk("errclr_alone", sel_err, 0);
    err_clr = 0;

    // Reset with two entries buffered.
    q_ready = 0; mode = 1; sel = 3'b010; in_valid = 1; data = 24'h00AB00;
    step(); step();
    in_valid = 0;
    chk("midrst_full", {q_valid, in_ready}, 2'b10);
    #2 rstb = 1'b0;
    #1;
    chk("midrst_q_valid", q_valid, 0);
    chk("midrst_q", q, 0);
    chk("midrst_in_ready", in_ready, 0);
    #3 rstb = 1'b1;
    step();
    chk("midrst_in_ready_edge", in_ready, 1);
    chk("midrst_no_output", q_valid, 0);

    // Randomized traffic against the queue model.
    model_q.delete();
    model_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      q_ready  = ($urandom_range(0, 2) != 0);
      sel      = N'($urandom);
      data     = N*W'({$urandom, $urandom});
      mode     = 1'($urandom);
      err_clr  = ($urandom_range(0, 7) == 0);
      chk("rnd_q_valid", q_valid, model_q.size() != 0);
      chk("rnd_q", q, (model_q.size() != 0) ? model_q[0] : 8'h00);
      chk("rnd_in_ready", in_ready, model_q.size() < 2);
      push = in_valid && (model_q.size() < 2);
      pop  = q_ready && (model_q.size() != 0);
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(ref_result(sel, data, mode));
      if (push && !mode && multi_bits(sel)) model_err = 1'b1;
      else if (err_clr) model_err = 1'b0;
      step();
      chk("rnd_sel_err", sel_err, model_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
